// File: rtl/mmio_memory_ctrl.sv
// mmio_memory_ctrl
//   Memory-mapped controller behind the CPU data port. It decodes one address
//   space into data RAM, screen RAM and a keyboard region (data + status). It
//   also buffers key codes from the keyboard front-end, gives the display
//   scan-out engine its own read-only screen port, and flags accesses to
//   unmapped addresses.
//
//   Optional feature macro: MMIO_KBD_FIFO_EN
//     defined   : the keyboard is a KBD_DEPTH-entry queue with back-pressure.
//     undefined : the keyboard is a single-entry latch that always accepts and
//                 overwrites.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in         in   CPU write data
//   address    in   CPU address
//   load       in   CPU write strobe
//   out        out  registered CPU read data (1-cycle latency)
//   key_in     in   key code from the keyboard front-end
//   key_valid  in   key code present
//   key_ready  out  keyboard buffer can accept a key
//   scan_addr  in   screen word offset for the display engine
//   scan_data  out  registered screen word (1-cycle latency)
//   bad_addr   out  pulse the cycle after an unmapped access
module mmio_memory_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_BASE  = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = 24576,
  parameter int KBD_DEPTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_W-1:0]               in,
  input  logic [ADDR_W-1:0]               address,
  input  logic                            load,
  output logic [DATA_W-1:0]               out,
  input  logic [DATA_W-1:0]               key_in,
  input  logic                            key_valid,
  output logic                            key_ready,
  input  logic [$clog2(SCREEN_WORDS)-1:0] scan_addr,
  output logic [DATA_W-1:0]               scan_data,
  output logic                            bad_addr
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int PTR_W  = $clog2(KBD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Storage (contents are deliberately not reset)
  logic [DATA_W-1:0] r_ram [RAM_WORDS];
  logic [DATA_W-1:0] r_scr [SCREEN_WORDS];

  // Keyboard control state
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  // Output registers
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_scan;
  logic              r_bad;

  // Address decode
  logic [31:0]       w_addr32;
  logic              w_is_ram;
  logic              w_is_scr;
  logic              w_is_kdata;
  logic              w_is_kstat;
  logic              w_unmapped;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [SCR_AW-1:0] w_scr_idx;

  // Keyboard handshake
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_kstat_wr;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_kstat;
  logic [DATA_W-1:0] w_rd_data;

  assign w_addr32   = 32'(address);
  assign w_is_ram   = (w_addr32 < 32'(RAM_WORDS));
  assign w_is_scr   = (w_addr32 >= 32'(SCREEN_BASE)) &&
                      (w_addr32 < 32'(SCREEN_BASE + SCREEN_WORDS));
  assign w_is_kdata = (w_addr32 == 32'(KBD_ADDR));
  assign w_is_kstat = (w_addr32 == 32'(KBD_ADDR + 1));
  assign w_unmapped = !(w_is_ram || w_is_scr || w_is_kdata || w_is_kstat);
  assign w_ram_idx  = RAM_AW'(w_addr32);
  assign w_scr_idx  = SCR_AW'(w_addr32 - 32'(SCREEN_BASE));
  assign w_kstat_wr = load && w_is_kstat;

  always_ff @(posedge clk) begin
    if (load && w_is_ram) r_ram[w_ram_idx] <= in;
    if (load && w_is_scr) r_scr[w_scr_idx] <= in;
  end

`ifdef MMIO_KBD_FIFO_EN
  logic [DATA_W-1:0] r_fifo [KBD_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;

  // Readiness depends on the registered count only, so a pop in the same
  // cycle never frees room for a push while full.
  assign key_ready = (r_count != CNT_W'(KBD_DEPTH));
  assign w_push    = key_valid && key_ready;
  assign w_drop    = key_valid && !key_ready;
  assign w_pop     = load && w_is_kdata && (r_count != '0);
  assign w_head    = r_fifo[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= key_in;
  end

  // Pointers wrap naturally because KBD_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [DATA_W-1:0] r_latch;

  // Single-entry latch: every key is accepted and overwrites the previous
  // one; losing an unread key counts as an overflow.
  assign key_ready = 1'b1;
  assign w_push    = key_valid;
  assign w_pop     = load && w_is_kdata;
  assign w_drop    = key_valid && (r_count != '0) && !w_pop;
  assign w_head    = r_latch;

  always_ff @(posedge clk) begin
    if (w_push) r_latch <= key_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_push) begin
      r_count <= CNT_W'(1);
    end else if (w_pop) begin
      r_count <= '0;
    end
  end
`endif

  // A drop in the same cycle as a status write wins, so the event is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_kstat_wr) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_kstat              = '0;
    w_kstat[CNT_W-1:0]   = r_count;
    w_kstat[DATA_W-1]    = r_ovf;
  end

  // Reads see pre-edge state, so a same-address write shows old data first.
  always_comb begin
    w_rd_data = '0;
    if (w_is_ram)
      w_rd_data = r_ram[w_ram_idx];
    else if (w_is_scr)
      w_rd_data = r_scr[w_scr_idx];
    else if (w_is_kdata)
      w_rd_data = (r_count != '0) ? w_head : '0;
    else if (w_is_kstat)
      w_rd_data = w_kstat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_scan <= '0;
      r_bad  <= 1'b0;
    end else begin
      r_out  <= w_rd_data;
      r_scan <= r_scr[scan_addr];
      r_bad  <= w_unmapped;
    end
  end

  assign out       = r_out;
  assign scan_data = r_scan;
  assign bad_addr  = r_bad;

endmodule

// File: tb/tb_mmio_memory_ctrl.sv
// Scoreboard bench for mmio_memory_ctrl. The driver computes the expected
// response of each cycle from a behavioural model (arrays + a key queue) and
// queues it; an independent monitor compares after every rising edge.
module tb_mmio_memory_ctrl;
  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 15;
  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_BASE  = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam int KBD_ADDR     = 24576;
  localparam int KBD_DEPTH    = 8;
  localparam int SA_W         = $clog2(SCREEN_WORDS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic              load = 1'b0;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] key_in = '0;
  logic              key_valid = 1'b0;
  logic              key_ready;
  logic [SA_W-1:0]   scan_addr = '0;
  logic [DATA_W-1:0] scan_data;
  logic              bad_addr;

  always #5 clk = ~clk;

  mmio_memory_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_WORDS(RAM_WORDS),
    .SCREEN_BASE(SCREEN_BASE), .SCREEN_WORDS(SCREEN_WORDS),
    .KBD_ADDR(KBD_ADDR), .KBD_DEPTH(KBD_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .address(addr), .load(load),
    .out(dout), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .scan_addr(scan_addr), .scan_data(scan_data), .bad_addr(bad_addr)
  );

  typedef struct {
    logic [DATA_W-1:0] out;
    bit                out_chk;
    logic [DATA_W-1:0] scan;
    bit                scan_chk;
    bit                bad;
    bit                kr;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model
  logic [DATA_W-1:0] m_ram    [RAM_WORDS];
  bit                m_ram_ok [RAM_WORDS];
  logic [DATA_W-1:0] m_scr    [SCREEN_WORDS];
  bit                m_scr_ok [SCREEN_WORDS];
  logic [DATA_W-1:0] kq[$];
  bit                m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] kstat_val();
    logic [DATA_W-1:0] v;
    v = DATA_W'(kq.size());
    v[DATA_W-1] = m_ovf;
    return v;
  endfunction

  function automatic bit model_ready();
`ifdef MMIO_KBD_FIFO_EN
    return kq.size() < KBD_DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic cyc(input int a, input logic [DATA_W-1:0] d, input bit ld,
                     input bit kv, input logic [DATA_W-1:0] k, input int sa);
    exp_t e;
    bit   is_ram, is_scr, is_kd, is_ks, kd_wr, drop;
    @(negedge clk);
    addr = ADDR_W'(a); din = d; load = ld; key_valid = kv; key_in = k;
    scan_addr = SA_W'(sa);
    is_ram = (a < RAM_WORDS);
    is_scr = (a >= SCREEN_BASE) && (a < SCREEN_BASE + SCREEN_WORDS);
    is_kd  = (a == KBD_ADDR);
    is_ks  = (a == KBD_ADDR + 1);
    // Responses from the state before this edge
    e.out_chk = 1'b1;
    e.out     = '0;
    if (is_ram) begin
      e.out_chk = m_ram_ok[a]; e.out = m_ram[a];
    end else if (is_scr) begin
      e.out_chk = m_scr_ok[a - SCREEN_BASE]; e.out = m_scr[a - SCREEN_BASE];
    end else if (is_kd) begin
      e.out = (kq.size() > 0) ? kq[0] : '0;
    end else if (is_ks) begin
      e.out = kstat_val();
    end
    e.bad      = !(is_ram || is_scr || is_kd || is_ks);
    e.scan_chk = m_scr_ok[sa];
    e.scan     = m_scr[sa];
    // State update at this edge
    if (ld && is_ram) begin m_ram[a] = d; m_ram_ok[a] = 1'b1; end
    if (ld && is_scr) begin m_scr[a - SCREEN_BASE] = d; m_scr_ok[a - SCREEN_BASE] = 1'b1; end
    kd_wr = ld && is_kd;
    drop  = 1'b0;
`ifdef MMIO_KBD_FIFO_EN
    begin
      bit do_push;
      do_push = kv && (kq.size() < KBD_DEPTH);
      drop    = kv && !do_push;
      if (kd_wr && kq.size() > 0) void'(kq.pop_front());
      if (do_push) kq.push_back(k);
    end
`else
    if (kv) begin
      drop = (kq.size() == 1) && !kd_wr;
      kq.delete();
      kq.push_back(k);
    end else if (kd_wr) begin
      kq.delete();
    end
`endif
    if (ld && is_ks) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    e.kr = model_ready();
    sb.push_back(e);
  endtask

  task automatic rd(input int a);
    cyc(a, '0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * KBD_DEPTH && kq.size() > 0; i++)
      cyc(KBD_ADDR, '0, 1'b1, 1'b0, '0, 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    load = 1'b0; key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out", dout, '0);
    chk("rst_scan", scan_data, '0);
    chk("rst_bad", bad_addr, 1'b0);
    chk("rst_key_ready", key_ready, 1'b1);
    kq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0, 1:    return int'($urandom_range(0, 15));
      2:       return RAM_WORDS - 1 - int'($urandom_range(0, 1));
      3, 4:    return SCREEN_BASE + int'($urandom_range(0, 15));
      5:       return SCREEN_BASE + SCREEN_WORDS - 1 - int'($urandom_range(0, 1));
      6, 7:    return KBD_ADDR;
      8:       return KBD_ADDR + 1;
      default: return int'($urandom_range(KBD_ADDR + 2, (1 << ADDR_W) - 1));
    endcase
  endfunction

  // Monitor: compares one queued expectation after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.out_chk)  chk("out", dout, e.out);
        if (e.scan_chk) chk("scan_data", scan_data, e.scan);
        chk("bad_addr", bad_addr, e.bad);
        chk("key_ready", key_ready, e.kr);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_out", dout, '0);
    chk("init_scan", scan_data, '0);
    chk("init_bad", bad_addr, 1'b0);
    chk("init_key_ready", key_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM write then read; empty keyboard status
    cyc(5, 16'h1234, 1'b1, 1'b0, '0, 0);
    rd(5);
    rd(KBD_ADDR + 1);

    // Screen write, scan port, same-cycle overwrite shows old value first
    cyc(SCREEN_BASE + 100, 16'hBEEF, 1'b1, 1'b0, '0, 100);
    cyc(SCREEN_BASE + 100, 16'hCAFE, 1'b1, 1'b0, '0, 100);
    cyc(SCREEN_BASE + 100, '0, 1'b0, 1'b0, '0, 100);
    rd(SCREEN_BASE + 100);

    // Three keys, status, head, pop
    cyc(KBD_ADDR + 1, '0, 1'b0, 1'b1, 16'h0041, 0);
    cyc(KBD_ADDR + 1, '0, 1'b0, 1'b1, 16'h0042, 0);
    cyc(KBD_ADDR + 1, '0, 1'b0, 1'b1, 16'h0043, 0);
    rd(KBD_ADDR + 1);
    rd(KBD_ADDR);
    cyc(KBD_ADDR, 16'hFFFF, 1'b1, 1'b0, '0, 0);
    rd(KBD_ADDR);
    rd(KBD_ADDR + 1);
    drain();

    // Fill past capacity, overflow flag, clear by status write
    for (int i = 0; i < KBD_DEPTH + 1; i++)
      cyc(KBD_ADDR + 1, '0, 1'b0, 1'b1, DATA_W'(16'h0050 + i), 0);
    rd(KBD_ADDR + 1);
    cyc(KBD_ADDR + 1, 16'h1234, 1'b1, 1'b0, '0, 0);
    rd(KBD_ADDR + 1);
    rd(KBD_ADDR);
    // Pop while full with a simultaneous push
    cyc(KBD_ADDR, '0, 1'b1, 1'b1, 16'h00AA, 0);
    rd(KBD_ADDR + 1);
    drain();

    // Count 3, push and pop together
    for (int i = 0; i < 3; i++) cyc(KBD_ADDR + 1, '0, 1'b0, 1'b1, DATA_W'(16'h0060 + i), 0);
    cyc(KBD_ADDR, '0, 1'b1, 1'b1, 16'h0063, 0);
    rd(KBD_ADDR + 1);
    rd(KBD_ADDR);
    // Pointer wrap through several laps with alternating pops
    for (int i = 0; i < 4 * KBD_DEPTH; i++)
      cyc(KBD_ADDR, '0, (i % 2 == 1), 1'b1, DATA_W'(16'h0100 + i), 0);
    for (int i = 0; i < KBD_DEPTH + 2; i++)
      cyc(KBD_ADDR, '0, 1'b1, 1'b0, '0, 0);
    rd(KBD_ADDR + 1);

    // Unmapped read/write: one-cycle pulse, no side effects
    cyc(24600, 16'h5555, 1'b1, 1'b0, '0, 0);
    rd(5);
    rd(24600);
    rd(KBD_ADDR + 1);

    // Asynchronous reset with keys queued
    for (int i = 0; i < 3; i++) cyc(5, '0, 1'b0, 1'b1, DATA_W'(16'h0070 + i), 0);
    cyc(KBD_ADDR + 2, '0, 1'b0, 1'b1, 16'h0073, 0);
    mid_reset();
    rd(KBD_ADDR + 1);
    rd(KBD_ADDR);
    rd(5);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int a, sa;
      a  = pick_addr();
      sa = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                       : SCREEN_WORDS - 1 - int'($urandom_range(0, 1));
      cyc(a, DATA_W'($urandom), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 9) < 4), DATA_W'($urandom), sa);
      if (i == 1500) mid_reset();
    end
    @(negedge clk);
    load = 1'b0; key_valid = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
